// File: rtl/cal_pid.sv
// Quadcopter attitude PID mixer: per-axis P/I/D terms mixed onto base throttle.
// Define CAL_PID_SAT_EN to clamp each motor mix to [0, 65535] instead of wrapping.
module cal_pid #(
  parameter int Kp = 100,
  parameter int Ki = 1,
  parameter int Kd = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cal_pid_en,
  input  logic [23:0] PWM_base,
  input  logic [23:0] pitch_error,
  input  logic [23:0] roll_error,
  input  logic [23:0] yaw_error,
  input  logic [23:0] i_pitch_error,
  input  logic [23:0] i_roll_error,
  input  logic [23:0] i_yaw_error,
  input  logic [23:0] d_pitch_error,
  input  logic [23:0] d_roll_error,
  input  logic [23:0] d_yaw_error,
  output logic [15:0] pwm_duty_1,
  output logic [15:0] pwm_duty_2,
  output logic [15:0] pwm_duty_3,
  output logic [15:0] pwm_duty_4
);

  localparam int W = 64;

  localparam logic signed [W-1:0] KP = W'(Kp);
  localparam logic signed [W-1:0] KI = W'(Ki);
  localparam logic signed [W-1:0] KD = W'(Kd);

  function automatic logic signed [W-1:0] sx(
    input logic [23:0] e
  );
    return {{(W-24){e[23]}}, e};
  endfunction

  function automatic logic signed [W-1:0] term(
    input logic [23:0] p,
    input logic [23:0] i,
    input logic [23:0] d
  );
    return KP * sx(p) + KI * sx(i) + KD * sx(d);
  endfunction

  logic signed [W-1:0] t_pitch;
  logic signed [W-1:0] t_roll;
  logic signed [W-1:0] t_yaw;
  logic signed [W-1:0] base;
  logic signed [W-1:0] m1;
  logic signed [W-1:0] m2;
  logic signed [W-1:0] m3;
  logic signed [W-1:0] m4;
  logic [15:0]         d1;
  logic [15:0]         d2;
  logic [15:0]         d3;
  logic [15:0]         d4;

  assign t_pitch = term(pitch_error, i_pitch_error, d_pitch_error);
  assign t_roll  = term(roll_error, i_roll_error, d_roll_error);
  assign t_yaw   = term(yaw_error, i_yaw_error, d_yaw_error);
  assign base    = {{(W-24){1'b0}}, PWM_base};

  assign m1 = base - t_pitch - t_roll - t_yaw;
  assign m2 = base - t_pitch + t_roll + t_yaw;
  assign m3 = base + t_pitch - t_roll + t_yaw;
  assign m4 = base + t_pitch + t_roll - t_yaw;

`ifdef CAL_PID_SAT_EN
  function automatic logic [15:0] sat(
    input logic signed [W-1:0] m
  );
    logic [15:0] r;
    r = m[15:0];
    if (m < 0)
      r = 16'h0000;
    else if (m > W'(65535))
      r = 16'hffff;
    return r;
  endfunction

  assign d1 = sat(m1);
  assign d2 = sat(m2);
  assign d3 = sat(m3);
  assign d4 = sat(m4);
`else
  // wrap mode keeps only the low 16 bits of each mix
  logic unused_hi;

  assign unused_hi = ^{m1[W-1:16], m2[W-1:16],
                       m3[W-1:16], m4[W-1:16]};

  assign d1 = m1[15:0];
  assign d2 = m2[15:0];
  assign d3 = m3[15:0];
  assign d4 = m4[15:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_duty_1 <= '0;
      pwm_duty_2 <= '0;
      pwm_duty_3 <= '0;
      pwm_duty_4 <= '0;
    end else if (cal_pid_en) begin
      pwm_duty_1 <= d1;
      pwm_duty_2 <= d2;
      pwm_duty_3 <= d3;
      pwm_duty_4 <= d4;
    end
  end

endmodule

// File: tb/tb_cal_pid.sv
// Directed bench for cal_pid: reset, mixing, hold, wrap/clamp and latency.
// Expected values are hand-computed from the mixing equations.
module tb_cal_pid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cal_pid_en = 1'b0;
  logic [23:0] PWM_base = '0;
  logic [23:0] pitch_error = '0;
  logic [23:0] roll_error = '0;
  logic [23:0] yaw_error = '0;
  logic [23:0] i_pitch_error = '0;
  logic [23:0] i_roll_error = '0;
  logic [23:0] i_yaw_error = '0;
  logic [23:0] d_pitch_error = '0;
  logic [23:0] d_roll_error = '0;
  logic [23:0] d_yaw_error = '0;
  logic [15:0] pwm_duty_1;
  logic [15:0] pwm_duty_2;
  logic [15:0] pwm_duty_3;
  logic [15:0] pwm_duty_4;

  int errors = 0;
  int checks = 0;

  cal_pid dut (
    .clk(clk),
    .rst_n(rst_n),
    .cal_pid_en(cal_pid_en),
    .PWM_base(PWM_base),
    .pitch_error(pitch_error),
    .roll_error(roll_error),
    .yaw_error(yaw_error),
    .i_pitch_error(i_pitch_error),
    .i_roll_error(i_roll_error),
    .i_yaw_error(i_yaw_error),
    .d_pitch_error(d_pitch_error),
    .d_roll_error(d_roll_error),
    .d_yaw_error(d_yaw_error),
    .pwm_duty_1(pwm_duty_1),
    .pwm_duty_2(pwm_duty_2),
    .pwm_duty_3(pwm_duty_3),
    .pwm_duty_4(pwm_duty_4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input int e1, input int e2,
                      input int e3, input int e4);
    check({tag, "_pwm1"}, pwm_duty_1, 16'(e1));
    check({tag, "_pwm2"}, pwm_duty_2, 16'(e2));
    check({tag, "_pwm3"}, pwm_duty_3, 16'(e3));
    check({tag, "_pwm4"}, pwm_duty_4, 16'(e4));
  endtask

  task automatic set_in(input int b, input int p, input int r, input int y,
                        input int ip, input int ir, input int iy,
                        input int dp, input int dr, input int dy);
    PWM_base      = 24'(b);
    pitch_error   = 24'(p);
    roll_error    = 24'(r);
    yaw_error     = 24'(y);
    i_pitch_error = 24'(ip);
    i_roll_error  = 24'(ir);
    i_yaw_error   = 24'(iy);
    d_pitch_error = 24'(dp);
    d_roll_error  = 24'(dr);
    d_yaw_error   = 24'(dy);
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held low with live inputs and enable
    set_in(1234, 5, 6, 7, 8, 9, 10, 11, 12, 13);
    cal_pid_en = 1'b1;
    #1;
    chk4("rst_init", 0, 0, 0, 0);
    edge_sample();
    edge_sample();
    chk4("rst_held", 0, 0, 0, 0);

    // release with enable low: stays 0
    @(negedge clk);
    cal_pid_en = 1'b0;
    rst_n = 1'b1;
    edge_sample();
    chk4("rel_no_en", 0, 0, 0, 0);

    // positive errors: T = 210/420/630
    @(negedge clk);
    set_in(1000, 1, 2, 3, 10, 20, 30, 100, 200, 300);
    cal_pid_en = 1'b1;
    edge_sample();
`ifdef CAL_PID_SAT_EN
    chk4("pos", 0, 1840, 1420, 1000);
`else
    chk4("pos", 65276, 1840, 1420, 1000);
`endif

    // negative errors
    @(negedge clk);
    set_in(1000, -1, -2, -3, -10, -20, -30, -100, -200, -300);
    edge_sample();
    chk4("neg", 2260, 160, 580, 1000);

    // hold with enable low
    @(negedge clk);
    cal_pid_en = 1'b0;
    set_in(2000, 100, 200, 300, 0, 0, 0, 0, 0, 0);
    edge_sample();
    edge_sample();
    edge_sample();
    chk4("hold", 2260, 160, 580, 1000);

    // large values: mixes -1230000/870000/450000/30000
    @(negedge clk);
    cal_pid_en = 1'b1;
    set_in(30000, 1000, 2000, 3000, 10000, 20000, 30000,
           100000, 200000, 300000);
    edge_sample();
`ifdef CAL_PID_SAT_EN
    chk4("large", 0, 65535, 65535, 30000);
`else
    chk4("large", 15184, 18032, 56784, 30000);
`endif

    // per-cycle latency: each output matches the previous edge's inputs
    @(negedge clk);
    set_in(500, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    edge_sample();
    chk4("lat0", 500, 500, 500, 500);
    @(negedge clk);
    set_in(600, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    edge_sample();
    chk4("lat1", 500, 500, 700, 700);
    @(negedge clk);
    set_in(700, 0, -1, 0, 0, 0, 0, 0, 0, 0);
    edge_sample();
    chk4("lat2", 800, 600, 800, 600);
    @(negedge clk);
    set_in(800, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    edge_sample();
    chk4("lat3", 795, 805, 805, 795);

    // asynchronous reset mid-run, away from any edge
    #2;
    rst_n = 1'b0;
    #1;
    chk4("rst_async", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cal_pid_en = 1'b0;
    edge_sample();
    chk4("rst_rel", 0, 0, 0, 0);
    @(negedge clk);
    cal_pid_en = 1'b1;
    edge_sample();
    chk4("rst_reen", 795, 805, 805, 795);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cal_pid.md
Name: cal_pid

Overview:
Quadcopter attitude PID mixer. Forms per-axis PID corrections (pitch, roll, yaw) from proportional, integral and derivative error inputs, mixes them onto a base throttle, and produces four registered 16-bit motor PWM duty values. Sits between the error/integrator/differentiator stage and the PWM generators.

Parameters:
Kp, 100, proportional gain, non-negative integer, applied to pitch/roll/yaw_error
Ki, 1, integral gain, non-negative integer, applied to i_*_error
Kd, 1, derivative gain, non-negative integer, applied to d_*_error

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
cal_pid_en  input  1  update enable; outputs load on a rising edge only when high
PWM_base  input  24  base throttle, unsigned
pitch_error  input  24  pitch P error, signed two's complement
roll_error  input  24  roll P error, signed
yaw_error  input  24  yaw P error, signed
i_pitch_error  input  24  pitch integrated error, signed
i_roll_error  input  24  roll integrated error, signed
i_yaw_error  input  24  yaw integrated error, signed
d_pitch_error  input  24  pitch error derivative, signed
d_roll_error  input  24  roll error derivative, signed
d_yaw_error  input  24  yaw error derivative, signed
pwm_duty_1  output  16  motor 1 duty
pwm_duty_2  output  16  motor 2 duty
pwm_duty_3  output  16  motor 3 duty
pwm_duty_4  output  16  motor 4 duty

Behaviour:
- One clock, clk; rst_n asynchronous, active-low. rst_n low clears all four outputs to 0 immediately, independent of clk, and holds them at 0 while low. This also applies mid-operation.
- Per axis X in {pitch, roll, yaw}: T_X = Kp*X_error + Ki*i_X_error + Kd*d_X_error, with signed arithmetic.
- Intermediate width: at least 48-bit signed, so there is no internal overflow.
- Mixing:
  - M1 = base - T_pitch - T_roll - T_yaw
  - M2 = base - T_pitch + T_roll + T_yaw
  - M3 = base + T_pitch - T_roll + T_yaw
  - M4 = base + T_pitch + T_roll - T_yaw
  - base is zero-extended.
- Output mapping (default build): pwm_duty_n = M_n[15:0], i.e. modulo 2^16 wrap, no clamping.
- Latency: fully combinational datapath, one output register stage. Inputs sampled at rising edge k with cal_pid_en=1 appear on the outputs after edge k; there is no extra pipeline.
- cal_pid_en=0 at an edge: all outputs hold their previous values, whatever the inputs do.
- No handshake and no state machine. Inputs must be stable around the sampling edge.
- Release of reset: outputs stay 0 until the first enabled edge.

Optional Feature:
CAL_PID_SAT_EN
- Defined: each M_n is clamped as a signed value before registering.
  - M_n < 0 gives 0.
  - M_n > 65535 gives 65535.
  - Otherwise M_n[15:0].
- Undefined: plain 16-bit truncation/wrap as in Behaviour.
- Latency, enable and reset behaviour are identical in both builds.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> all outputs 0 immediately. Assert rst_n=0 mid-run after nonzero outputs -> outputs 0 without waiting for an edge.
- Positive errors (default params): base=1000, errors 1/2/3, i 10/20/30, d 100/200/300, en=1, one edge -> T=210/420/630.
  - Default build: pwm1=65276 (wrapped -260), pwm2=1840, pwm3=1420, pwm4=1000.
  - CAL_PID_SAT_EN build: pwm1=0.
- Negative errors: same magnitudes negated, base=1000, one edge -> pwm1=2260, pwm2=160, pwm3=580, pwm4=1000.
- Hold: after the previous case set en=0, base=2000, errors 100/200/300, clock several edges -> outputs remain 2260/160/580/1000.
- Large values: base=30000, errors 1000/2000/3000, i 10000/20000/30000, d 100000/200000/300000, en=1, one edge.
  - Default build: each output equals the low 16 bits of its exact mix.
  - CAL_PID_SAT_EN build: pwm1=0, pwm2=65535.
- Latency: change inputs each cycle with en=1 -> each output reflects the inputs sampled at the immediately preceding edge.
